// File: rtl/pseudorandom_ff_array.sv
// rtl/pseudorandom_ff_array.sv - multi-chain throttled XOR flop array for power/toggle stress
// Optional feature macro: STRESS_SIGNATURE_EN (adds 32-bit MISR output signature).
module pseudorandom_ff_array #(
  parameter int NUM_CELLS   = 60,
  parameter int NUM_CHAINS  = 4,
  parameter int RAMP_CYCLES = 256,
  parameter int DUTY_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [DUTY_WIDTH-1:0] duty,
  output logic [NUM_CHAINS-1:0] active,
  output logic                  busy,
  output logic                  dummy,
  output logic [15:0]           dummy_address,
  output logic [15:0]           dummy_data
`ifdef STRESS_SIGNATURE_EN
  ,
  output logic [31:0]           signature
`endif
);

  localparam int RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);
  localparam logic [NUM_CHAINS-1:0] CHAIN_ONE = NUM_CHAINS'(1);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t                state, state_nxt;
  logic [NUM_CHAINS-1:0] active_nxt;
  logic [RW-1:0]         ramp_cnt, ramp_nxt;
  logic                  ramp_tick;
  logic [DUTY_WIDTH-1:0] phase;
  logic                  step;
  logic [NUM_CHAINS-1:0] cell0;
  logic [31:0]           chain0_low;

  // One chain advance: cells 0..2 fold in the toggle flop and the chain tail,
  // the rest XOR their three predecessors.
  function automatic logic [NUM_CELLS-1:0] chain_next(input logic [NUM_CELLS-1:0] c,
                                                      input logic t);
    logic [NUM_CELLS-1:0] n;
    n[0] = t ^ c[NUM_CELLS-1] ^ c[NUM_CELLS-2];
    n[1] = c[0] ^ t ^ c[NUM_CELLS-1];
    n[2] = c[1] ^ c[0] ^ t;
    n[NUM_CELLS-1:3] = c[NUM_CELLS-2:2] ^ c[NUM_CELLS-3:1] ^ c[NUM_CELLS-4:0];
    return n;
  endfunction

  assign step      = (&duty) | (phase < duty);
  assign ramp_tick = (ramp_cnt == RAMP_LAST);
  assign busy      = (state != IDLE);

  // Free-running throttle phase counter.
  always_ff @(posedge clk) begin
    if (!resetn) phase <= '0;
    else         phase <= phase + 1'b1;
  end

  // Run/stop FSM next state, thermometer mask and ramp counter.
  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    case (state)
      IDLE: begin
        if (run) begin
          state_nxt  = RAMP_UP;
          active_nxt = CHAIN_ONE;
        end
      end
      RAMP_UP: begin
        if (!run)           state_nxt  = RAMP_DOWN;
        else if (&active)   state_nxt  = RUN;
        else if (ramp_tick) active_nxt = (active << 1) | CHAIN_ONE;
      end
      RUN: begin
        if (!run) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (run)                 state_nxt  = RAMP_UP;
        else if (active == '0)   state_nxt  = IDLE;
        else if (ramp_tick)      active_nxt = active >> 1;
      end
      default: state_nxt = IDLE;
    endcase
    if ((state_nxt != state) || ramp_tick) ramp_nxt = '0;
    else                                   ramp_nxt = ramp_cnt + 1'b1;
  end

  // FSM state, enable mask and ramp counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      active   <= '0;
      ramp_cnt <= '0;
    end else begin
      state    <= state_nxt;
      active   <= active_nxt;
      ramp_cnt <= ramp_nxt;
    end
  end

  for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_chain
    logic [NUM_CELLS-1:0] c;
    logic                 t;

    // Chain is forced to zero whenever it is (or is about to be) disabled.
    always_ff @(posedge clk) begin
      if (!resetn || !active_nxt[k]) begin
        c <= '0;
        t <= 1'b0;
      end else if (active[k] && step) begin
        c <= chain_next(c, t);
        t <= ~t;
      end
    end

    assign cell0[k] = c[0];
    if (k == 0) begin : g_tap
      assign chain0_low = c[31:0];
    end
  end

  assign dummy         = ^cell0;
  assign dummy_address = chain0_low[15:0];
  assign dummy_data    = chain0_low[31:16];

`ifdef STRESS_SIGNATURE_EN
  // MISR over dummy, x^32+x^22+x^2+x+1, advancing only while stressing.
  always_ff @(posedge clk) begin
    if (!resetn)          signature <= 32'hFFFF_FFFF;
    else if (busy && step) signature <= {signature[30:0],
                                         signature[31] ^ signature[21] ^ signature[1] ^ signature[0]}
                                        ^ {31'b0, dummy};
  end
`endif

endmodule

// File: tb/tb_pseudorandom_ff_array.sv
// tb/tb_pseudorandom_ff_array.sv - randomized model-checked bench for pseudorandom_ff_array
module tb_pseudorandom_ff_array;

  localparam int NCELL = 60;
  localparam int NCH   = 4;
  localparam int RAMP  = 4;
  localparam int DW    = 4;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_RUN  = 2;
  localparam int M_DOWN = 3;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           run = 1'b0;
  logic [DW-1:0]  duty = '0;
  logic [NCH-1:0] active;
  logic           busy;
  logic           dummy;
  logic [15:0]    dummy_address;
  logic [15:0]    dummy_data;
`ifdef STRESS_SIGNATURE_EN
  logic [31:0]    signature;
`endif

  pseudorandom_ff_array #(
    .NUM_CELLS  (NCELL),
    .NUM_CHAINS (NCH),
    .RAMP_CYCLES(RAMP),
    .DUTY_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .run          (run),
    .duty         (duty),
    .active       (active),
    .busy         (busy),
    .dummy        (dummy),
    .dummy_address(dummy_address),
    .dummy_data   (dummy_data)
`ifdef STRESS_SIGNATURE_EN
    ,
    .signature    (signature)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: mode, number of enabled chains, ramp count, phase.
  int                m_mode  = M_IDLE;
  int                m_on    = 0;
  int                m_cnt   = 0;
  int                m_phase = 0;
  logic [NCELL-1:0]  m_cell [NCH];
  logic [NCH-1:0]    m_tog   = '0;
`ifdef STRESS_SIGNATURE_EN
  logic [31:0]       m_sig   = 32'hFFFF_FFFF;
`endif

  // Reference model advanced on each rising edge from the sampled inputs.
  always @(posedge clk) begin : ref_model
    logic             st;
    logic             tk;
    int               mode_n;
    int               on_n;
    logic [NCELL-1:0] o;
    logic [NCELL-1:0] n;
`ifdef STRESS_SIGNATURE_EN
    logic             od;
`endif
    if (!resetn) begin
      m_mode  = M_IDLE;
      m_on    = 0;
      m_cnt   = 0;
      m_phase = 0;
      m_tog   = '0;
      for (int k = 0; k < NCH; k++) m_cell[k] = '0;
`ifdef STRESS_SIGNATURE_EN
      m_sig = 32'hFFFF_FFFF;
`endif
    end else begin
      st = (duty == {DW{1'b1}}) || (m_phase < int'(duty));
      tk = (m_cnt == RAMP - 1);
`ifdef STRESS_SIGNATURE_EN
      od = 1'b0;
      for (int k = 0; k < NCH; k++) od = od ^ m_cell[k][0];
      if (m_mode != M_IDLE && st)
        m_sig = {m_sig[30:0], m_sig[31] ^ m_sig[21] ^ m_sig[1] ^ m_sig[0]} ^ {31'b0, od};
`endif
      mode_n = m_mode;
      on_n   = m_on;
      case (m_mode)
        M_IDLE: if (run) begin mode_n = M_UP; on_n = 1; end
        M_UP: begin
          if (!run)            mode_n = M_DOWN;
          else if (m_on == NCH) mode_n = M_RUN;
          else if (tk)         on_n = m_on + 1;
        end
        M_RUN: if (!run) mode_n = M_DOWN;
        default: begin
          if (run)            mode_n = M_UP;
          else if (m_on == 0) mode_n = M_IDLE;
          else if (tk)        on_n = m_on - 1;
        end
      endcase
      for (int k = 0; k < NCH; k++) begin
        if (k >= on_n) begin
          m_cell[k] = '0;
          m_tog[k]  = 1'b0;
        end else if (k < m_on && st) begin
          o    = m_cell[k];
          n[0] = m_tog[k] ^ o[NCELL-1] ^ o[NCELL-2];
          n[1] = o[0] ^ m_tog[k] ^ o[NCELL-1];
          n[2] = o[1] ^ o[0] ^ m_tog[k];
          for (int i = 3; i < NCELL; i++) n[i] = o[i-1] ^ o[i-2] ^ o[i-3];
          m_cell[k] = n;
          m_tog[k]  = ~m_tog[k];
        end
      end
      m_cnt   = (mode_n != m_mode || tk) ? 0 : m_cnt + 1;
      m_mode  = mode_n;
      m_on    = on_n;
      m_phase = (m_phase + 1) % (1 << DW);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    logic [NCH-1:0] ea;
    logic           ed;
    ea = NCH'((1 << m_on) - 1);
    ed = 1'b0;
    for (int k = 0; k < NCH; k++) ed = ed ^ m_cell[k][0];
    check_eq({tag, "_active"}, 32'(active), 32'(ea));
    check_eq({tag, "_busy"}, 32'(busy), 32'(m_mode != M_IDLE));
    check_eq({tag, "_dummy"}, 32'(dummy), 32'(ed));
    check_eq({tag, "_addr"}, 32'(dummy_address), 32'(m_cell[0][15:0]));
    check_eq({tag, "_data"}, 32'(dummy_data), 32'(m_cell[0][31:16]));
`ifdef STRESS_SIGNATURE_EN
    check_eq({tag, "_sig"}, signature, m_sig);
`endif
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_active"}, 32'(active), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_dummy"}, 32'(dummy), 32'h0);
    check_eq({tag, "_addr"}, 32'(dummy_address), 32'h0);
    check_eq({tag, "_data"}, 32'(dummy_data), 32'h0);
`ifdef STRESS_SIGNATURE_EN
    check_eq({tag, "_sig"}, signature, 32'hFFFF_FFFF);
`endif
  endtask

  // Chain 0 just enabled at T with full duty: first three steps are known.
  task automatic check_start_sequence(input string tag);
    tick();
    check_eq({tag, "_T_active"}, 32'(active), 32'h1);
    check_eq({tag, "_T_busy"}, 32'(busy), 32'h1);
    tick();
    check_eq({tag, "_step1"}, 32'(dummy_address), 32'h0000);
    tick();
    check_eq({tag, "_step2"}, 32'(dummy_address), 32'h0007);
    tick();
    check_eq({tag, "_step3"}, 32'(dummy_address), 32'h002A);
    compare_model({tag, "_seq"});
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) m_cell[k] = '0;

    resetn = 1'b0;
    run    = 1'b1;
    duty   = '1;
    repeat (3) tick();
    check_zero_outputs("reset");

    resetn = 1'b1;
    check_start_sequence("up");
    tick();
    check_eq("up_T4_active", 32'(active), 32'h3);
    repeat (4) tick();
    check_eq("up_T8_active", 32'(active), 32'h7);
    repeat (4) tick();
    check_eq("up_T12_active", 32'(active), 32'hF);
    check_eq("up_T12_busy", 32'(busy), 32'h1);
    tick();

    duty = 4'd4;
    repeat (64) begin
      tick();
      compare_model("duty4");
    end
    duty = '0;
    repeat (64) begin
      tick();
      compare_model("duty0");
    end

    run = 1'b0;
    tick();
    check_eq("down_U_active", 32'(active), 32'hF);
    check_eq("down_U_busy", 32'(busy), 32'h1);
    repeat (4) tick();
    check_eq("down_U4_active", 32'(active), 32'h7);
    repeat (12) tick();
    check_eq("down_U16_active", 32'(active), 32'h0);
    check_eq("down_U16_busy", 32'(busy), 32'h1);
    tick();
    check_eq("down_U17_busy", 32'(busy), 32'h0);

    duty = '1;
    run  = 1'b1;
    tick();
    check_eq("abort_T_active", 32'(active), 32'h1);
    repeat (4) tick();
    check_eq("abort_T4_active", 32'(active), 32'h3);
    run = 1'b0;
    tick();
    check_eq("abort_D_active", 32'(active), 32'h3);
    check_eq("abort_D_busy", 32'(busy), 32'h1);
    repeat (4) tick();
    check_eq("abort_D4_active", 32'(active), 32'h1);
    run = 1'b1;
    tick();
    check_eq("abort_D5_active", 32'(active), 32'h1);
    check_eq("abort_D5_busy", 32'(busy), 32'h1);
    repeat (4) tick();
    check_eq("abort_D9_active", 32'(active), 32'h3);
    compare_model("abort");

    repeat (20) tick();
    check_eq("run_active", 32'(active), 32'hF);
    resetn = 1'b0;
    tick();
    check_zero_outputs("midreset");
    resetn = 1'b1;
    check_start_sequence("rerun");

    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 63) == 0) duty = DW'($urandom);
      resetn = ($urandom_range(0, 499) != 0);
      tick();
      compare_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pseudorandom_ff_array.md
Name: pseudorandom_ff_array

Overview:
- Multi-chain, throttleable successor to the single pseudorandom XOR flip-flop chain used for FPGA power/toggle stress.
- Instantiates NUM_CHAINS independent NUM_CELLS-long XOR chains.
- Adds a run/stop state machine that ramps chains on and off one at a time to limit supply current steps.
- Adds a duty-cycle throttle that sets average toggle rate, plus the usual dummy bus outputs for loading routing.

Parameters:
- NUM_CELLS, 60: flops per chain; legal range >= 32.
- NUM_CHAINS, 4: number of independent chains; legal range 1..32.
- RAMP_CYCLES, 256: clock cycles between successive chain enables/disables; legal range >= 1.
- DUTY_WIDTH, 4: width of the duty input and the phase counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- run  in  DUTY_WIDTH=n/a, width 1  level request: 1 = stress on, 0 = stress off.
- duty  in  DUTY_WIDTH  throttle; chains advance on (duty / 2^DUTY_WIDTH) of cycles; all-ones = every cycle.
- active  out  NUM_CHAINS  thermometer mask of enabled chains; bit k = chain k enabled.
- busy  out  1  high whenever state != IDLE.
- dummy  out  1  XOR of cell 0 across all chains.
- dummy_address  out  16  chain 0 cells 15..0.
- dummy_data  out  16  chain 0 cells 31..16.

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE, active=0, phase=0, ramp counter=0.
  - All chain cells and per-chain toggle flops = 0.
  - Every output = 0. Reset applied mid-operation takes effect on that edge, with no ramp-down.
- Phase counter: a DUTY_WIDTH-bit free-running counter that wraps 2^DUTY_WIDTH-1 -> 0.
- step: combinational, defined as (duty == all ones) | (phase < duty). duty=0 freezes all chains. duty changes apply on the next cycle.
- Chain k update, on a posedge where active[k] & step. t_k is the chain's toggle flop; "old" means the value before the edge.
  - t_k <= ~t_k.
  - c0 <= t_k ^ c[N-1] ^ c[N-2].
  - c1 <= c0 ^ t_k ^ c[N-1].
  - c2 <= c1 ^ c0 ^ t_k.
  - ci <= c[i-1] ^ c[i-2] ^ c[i-3] for i >= 3, where N = NUM_CELLS.
- Chain k with active[k]=1 and step=0: holds.
- Chain k with active[k]=0: cells and t_k are held at 0. A chain is cleared on the same edge its active bit falls.
- The ramp counter counts 0..RAMP_CYCLES-1, then wraps to 0 and issues a ramp tick. It is cleared on every state change.
- FSM transitions:
  - IDLE: run=1 -> RAMP_UP, and active <= 1 on the same edge.
  - RAMP_UP:
    - run=0 -> RAMP_DOWN; active is unchanged.
    - Else if active is all ones -> RUN.
    - Else, on a ramp tick, active <= {active, 1'b1} (next-higher chain enabled).
  - RUN: run=0 -> RAMP_DOWN.
  - RAMP_DOWN:
    - run=1 -> RAMP_UP; active is unchanged.
    - Else if active == 0 -> IDLE.
    - Else, on a ramp tick, active <= active >> 1 (highest chain disabled first).
- Up-ramp timing, run sampled high at edge T:
  - active[0] set at T.
  - active[k] set at T + k*RAMP_CYCLES.
  - RUN entered at T + (NUM_CHAINS-1)*RAMP_CYCLES + 1.
- NUM_CHAINS=1: RAMP_UP lasts exactly one cycle.
- Down-ramp timing, run sampled low at edge T while in RUN:
  - RAMP_DOWN entered at T.
  - Highest chain cleared at T + RAMP_CYCLES.
  - Last chain cleared at T + NUM_CHAINS*RAMP_CYCLES.
  - IDLE entered at T + NUM_CHAINS*RAMP_CYCLES + 1.
- busy and active are registered outputs. dummy, dummy_address and dummy_data are wires from the registered cells.

Optional Feature:
- Macro: STRESS_SIGNATURE_EN.
- Defined:
  - Adds output port signature, width 32: a MISR with polynomial x^32+x^22+x^2+x+1.
  - Next value: {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ {31'b0, dummy}.
  - Updates on every edge where busy & step. Holds otherwise.
  - Resets to 32'hFFFFFFFF.
  - Used to check bit-exact chain behaviour on silicon.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with run=1 and duty=all ones -> active=0, busy=0, dummy=0, dummy_address=0x0000, dummy_data=0x0000.
- Ramp up/down (NUM_CHAINS=4, RAMP_CYCLES=4): run rises at edge T -> active=0001@T, 0011@T+4, 0111@T+8, 1111@T+12, busy=1. Drop run in RUN at edge U -> active=0111@U+4, 0000@U+16, busy=0@U+17.
- Sequence (NUM_CHAINS=1, duty=all ones): chain 0 steps after enable -> dummy_address = 0x0000 after step 1, 0x0007 after step 2, 0x002A after step 3.
- Throttle (DUTY_WIDTH=4, duty=4): in RUN over 64 cycles -> exactly 16 chain steps. duty=0 -> dummy_address constant for 64 cycles.
- Abort: run drops while active=0011 in RAMP_UP -> RAMP_DOWN next edge, active=0001 after 4 cycles. Run reasserted while active=0001 -> RAMP_UP with active kept at 0001.
- Mid-run reset with STRESS_SIGNATURE_EN: resetn=0 for 1 cycle in RUN -> all outputs 0 next edge, signature=32'hFFFFFFFF. Sequence check from the ramp case then repeats bit-exactly.
